// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between instruction fetch (IF)
//              and load/store (DM), with a stall output and a memory watchdog.
//
// Each access runs IDLE -> BUSY -> RESP -> IDLE. The winner is granted
// combinationally in IDLE. Its payload is registered onto mem_*. mem_req is held
// in BUSY until mem_ack or a watchdog abort. The owner's rvalid pulses in RESP.
//
// Configuration macro: ARB_RR_EN
//   undefined : fixed priority, DM wins a same-cycle tie.
//   defined   : round-robin, a tie goes to the requester that was not the last owner.
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   if_req_i, if_addr_i                fetch request / address (held until if_rvalid_o)
//   if_gnt_o, if_rvalid_o, if_rdata_o  fetch grant pulse, data-valid pulse, instruction
//   dm_req_i, dm_we_i, dm_be_i,
//   dm_addr_i, dm_wdata_i              data request and payload (held until dm_rvalid_o)
//   dm_gnt_o, dm_rvalid_o, dm_rdata_o  data grant pulse, done pulse, load data (0 for stores)
//   mem_req_o, mem_we_o, mem_be_o,
//   mem_addr_o, mem_wdata_o            memory request and registered payload
//   mem_ack_i, mem_rdata_i             memory completion and read data
//   stall_o                            hold PC / pipeline while a request is outstanding
//   timeout_err_o                      sticky watchdog abort flag
module mem_arbiter #(
  parameter int D_WIDTH     = 32,
  parameter int A_WIDTH     = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               if_req_i,
  input  logic [A_WIDTH-1:0] if_addr_i,
  output logic               if_gnt_o,
  output logic               if_rvalid_o,
  output logic [D_WIDTH-1:0] if_rdata_o,
  input  logic               dm_req_i,
  input  logic               dm_we_i,
  input  logic [3:0]         dm_be_i,
  input  logic [A_WIDTH-1:0] dm_addr_i,
  input  logic [D_WIDTH-1:0] dm_wdata_i,
  output logic               dm_gnt_o,
  output logic               dm_rvalid_o,
  output logic [D_WIDTH-1:0] dm_rdata_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [3:0]         mem_be_o,
  output logic [A_WIDTH-1:0] mem_addr_o,
  output logic [D_WIDTH-1:0] mem_wdata_o,
  input  logic               mem_ack_i,
  input  logic [D_WIDTH-1:0] mem_rdata_i,
  output logic               stall_o,
  output logic               timeout_err_o
);
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               mem_we_q, mem_we_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [A_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [D_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [D_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [D_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic               terr_q, terr_d;
  logic               pick_dm, grant_if, grant_dm, done;
  logic [D_WIDTH-1:0] resp_data;

  // owner_q doubles as the last-owner record for round-robin; it resets to DM
  // so the first tie after reset goes to IF.
`ifdef ARB_RR_EN
  assign pick_dm = dm_req_i && (!if_req_i || owner_q == OWN_IF);
`else
  assign pick_dm = dm_req_i;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wdog_d      = wdog_q;
    terr_d      = terr_q;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    done        = 1'b0;
    resp_data   = '0;
    unique case (state_q)
      IDLE: begin
        if (if_req_i || dm_req_i) begin
          state_d  = BUSY;
          grant_dm = pick_dm;
          grant_if = !pick_dm;
          owner_d  = pick_dm ? OWN_DM : OWN_IF;
          mem_we_d   = pick_dm ? dm_we_i : 1'b0;
          mem_be_d   = pick_dm ? dm_be_i : 4'hF;
          mem_addr_d = pick_dm ? dm_addr_i : if_addr_i;
          mem_wdata_d = pick_dm ? dm_wdata_i : mem_wdata_q;
        end
      end
      BUSY: begin
        // An ack on the timeout cycle takes precedence over the abort.
        if (mem_ack_i) begin
          state_d   = RESP;
          done      = 1'b1;
          resp_data = (owner_q == OWN_DM && mem_we_q) ? '0 : mem_rdata_i;
        end else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
          state_d   = RESP;
          done      = 1'b1;
          terr_d    = 1'b1;
          resp_data = D_WIDTH'(32'hDEAD_BEEF);
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        wdog_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    if_rdata_d = (done && owner_q == OWN_IF) ? resp_data : if_rdata_q;
    dm_rdata_d = (done && owner_q == OWN_DM) ? resp_data : dm_rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= OWN_DM;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wdog_q      <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wdog_q      <= wdog_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      terr_q      <= terr_d;
    end
  end

  // Grants are combinational from the requests, so they are masked by reset to
  // keep every output low while reset is asserted.
  assign if_gnt_o      = rst_ni && grant_if;
  assign dm_gnt_o      = rst_ni && grant_dm;
  assign if_rvalid_o   = (state_q == RESP) && (owner_q == OWN_IF);
  assign dm_rvalid_o   = (state_q == RESP) && (owner_q == OWN_DM);
  assign if_rdata_o    = if_rdata_q;
  assign dm_rdata_o    = dm_rdata_q;
  assign mem_req_o     = (state_q == BUSY);
  assign mem_we_o      = mem_we_q;
  assign mem_be_o      = mem_be_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign timeout_err_o = terr_q;
  assign stall_o       = (if_req_i && !if_rvalid_o) || (dm_req_i && !dm_rvalid_o);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a response scoreboard and memory responder
module tb_mem_arbiter;
  localparam int TO = 64;

  typedef struct {
    logic        dm;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall, timeout_err;

  int   total = 0, passed = 0, failed = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   gnt_log[$];
  bit   ack_en = 1;
  int   ack_dly = 0;
  int   ack_cnt = 0;

  mem_arbiter #(.D_WIDTH(32), .A_WIDTH(32), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .stall_o(stall), .timeout_err_o(timeout_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rv(input bit dm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dm ? dm_rvalid : if_rvalid) return;
    end
    chk(dm ? "dm_rvalid_wait" : "if_rvalid_wait", 0, 1);
  endtask

  // Memory responder: acks ack_dly cycles into the request with model data.
  initial begin
    mem_ack = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (mem_req && ack_en) begin
        mem_ack = (ack_cnt == ack_dly);
        mem_rdata = mem_ack ? model(mem_addr) : 32'h0;
        ack_cnt++;
      end else begin
        mem_ack = 0;
        mem_rdata = 0;
        ack_cnt = 0;
      end
    end
  end

  // Monitor: logs grants and pops the scoreboard on every rvalid.
  always @(negedge clk) begin
    #2;
    if (if_gnt) gnt_log.push_back(0);
    if (dm_gnt) gnt_log.push_back(1);
    if (if_rvalid || dm_rvalid) begin
      if (sb.size() == 0) chk("unexpected_rvalid", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("rv_owner", dm_rvalid, mon_e.dm);
        chk("rv_both", if_rvalid & dm_rvalid, 0);
        chk("rv_rdata", dm_rvalid ? dm_rdata : if_rdata, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy, n_rv, t_first, t_second, cyc;
    bit got;
    int first_dm;
    rst_n = 0; if_req = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
    repeat (2) @(negedge clk);
    if_req = 1; if_addr = 0; #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_dm_gnt", dm_gnt, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_dm_rvalid", dm_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // fetch right after reset release
    @(negedge clk); rst_n = 1; sb.push_back('{1'b0, model(0)}); #1;
    chk("t1_if_gnt", if_gnt, 1);
    chk("t1_mem_req_n", mem_req, 0);
    @(negedge clk);
    chk("t1_mem_req", mem_req, 1);
    chk("t1_if_gnt_pulse", if_gnt, 0);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_mem_be", mem_be, 4'hF);
    chk("t1_mem_addr", mem_addr, 0);
    chk("t1_stall_busy", stall, 1);
    @(negedge clk);
    chk("t1_if_rvalid", if_rvalid, 1);
    chk("t1_if_rdata", if_rdata, 32'h0050_0093);
    chk("t1_stall_rv", stall, 0);
    chk("t1_mem_req_drop", mem_req, 0);
    if_req = 0;

    // store, payload changed while busy must be ignored
    @(negedge clk);
    ack_dly = 3;
    dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 32'h100; dm_wdata = 32'hCAFE_F00D;
    sb.push_back('{1'b1, 32'h0}); #1;
    chk("t2_dm_gnt", dm_gnt, 1);
    chk("t2_if_gnt", if_gnt, 0);
    @(negedge clk);
    chk("t2_mem_req", mem_req, 1);
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_be", mem_be, 4'hF);
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    dm_addr = 32'h200; dm_wdata = 0; dm_we = 0; dm_be = 0;
    @(negedge clk);
    chk("t2_hold_addr", mem_addr, 32'h100);
    chk("t2_hold_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("t2_hold_we", mem_we, 1);
    chk("t2_stall", stall, 1);
    wait_rv(1);
    dm_req = 0;
    chk("t2_if_rdata_hold", if_rdata, 32'h0050_0093);

    // ack on the final watchdog cycle wins
    @(negedge clk);
    ack_dly = TO - 1;
    if_req = 1; if_addr = 32'h40; sb.push_back('{1'b0, model(32'h40)});
    wait_rv(0);
    if_req = 0;
    chk("ack_at_limit_no_err", timeout_err, 0);

    // watchdog abort
    @(negedge clk);
    ack_en = 0;
    if_req = 1; if_addr = 32'h80; sb.push_back('{1'b0, 32'hDEAD_BEEF});
    busy = 0; got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if_rvalid) begin got = 1; break; end
      busy += int'(mem_req);
    end
    if_req = 0;
    chk("t4_rvalid_seen", got, 1);
    chk("t4_busy_cycles", busy, TO);
    chk("t4_timeout_err", timeout_err, 1);
    ack_en = 1; ack_dly = 1;
    @(negedge clk);
    dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h104;
    sb.push_back('{1'b1, model(32'h104)});
    wait_rv(1);
    dm_req = 0;
    chk("t4_err_sticky", timeout_err, 1);

    // reset while busy
    @(negedge clk);
    ack_en = 0;
    if_req = 1; if_addr = 32'hC0; sb.push_back('{1'b0, model(32'hC0)});
    repeat (3) @(negedge clk);
    chk("t5_busy_before", mem_req, 1);
    rst_n = 0; void'(sb.pop_back()); #1;
    chk("t5_mem_req", mem_req, 0);
    chk("t5_if_gnt", if_gnt, 0);
    chk("t5_if_rvalid", if_rvalid, 0);
    chk("t5_timeout_clr", timeout_err, 0);
    if_req = 0;
    repeat (2) @(negedge clk);

    // simultaneous requests right after release
    ack_en = 1; ack_dly = 0;
    gnt_log.delete();
`ifdef ARB_RR_EN
    first_dm = 0;
    sb.push_back('{1'b0, model(32'h10)});
    sb.push_back('{1'b1, model(32'h20)});
`else
    first_dm = 1;
    sb.push_back('{1'b1, model(32'h20)});
    sb.push_back('{1'b0, model(32'h10)});
`endif
    if_req = 1; if_addr = 32'h10;
    dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h20;
    rst_n = 1;
    n_rv = 0; t_first = 0; t_second = 0; cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (if_rvalid || dm_rvalid) begin
        n_rv++;
        if (n_rv == 1) t_first = cyc; else t_second = cyc;
      end
      if (if_rvalid) if_req = 0;
      if (dm_rvalid) dm_req = 0;
      if (n_rv == 2) break;
    end
    chk("t3_both_done", n_rv, 2);
    chk("t3_spacing", t_second - t_first, 3);
    chk("t3_gnt_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("t3_first_gnt", gnt_log[0], first_dm);
      chk("t3_second_gnt", gnt_log[1], 1 - first_dm);
    end

    // request held through rvalid: one grant per access, re-grant in next idle
    @(negedge clk);
    gnt_log.delete();
    if_req = 1; if_addr = 32'h44; sb.push_back('{1'b0, model(32'h44)});
    wait_rv(0);
    chk("t6_no_gnt_in_resp", if_gnt, 0);
    @(negedge clk);
    sb.push_back('{1'b0, model(32'h44)}); #1;
    chk("t6_regrant", if_gnt, 1);
    wait_rv(0);
    if_req = 0;
    repeat (3) @(negedge clk);
    chk("t6_gnt_count", gnt_log.size(), 2);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
